// File: rtl/pulpissimo_rst_cond.sv
// Board-level reset conditioner for the PULPissimo pad_reset_n input: synchronises and
// debounces two push-button pads, stretches the reset, and records cause and event count.
module pulpissimo_rst_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 1024
) (
  input  logic       ref_clk_i,
  input  logic       rst_i,
  input  logic       pad_reset_i,
  input  logic       pad_reset2_i,
  output logic       rst_n_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o
);

  localparam int unsigned DcntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HcntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DcntW-1:0] DcntMax = DcntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HcntW-1:0] HcntMax = HcntW'(HOLD_CYCLES - 1);

  typedef enum logic {StHold, StRun} state_e;

  logic [SYNC_STAGES-1:0] sync1_q;
  logic [SYNC_STAGES-1:0] sync2_q;
  logic                   req1;
  logic                   req2;
  logic                   req_s;

  logic                   deb_q, deb_d;
  logic [DcntW-1:0]       dcnt_q, dcnt_d;

  state_e                 state_q, state_d;
  logic [HcntW-1:0]       hcnt_q, hcnt_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             count_q, count_d;
  logic                   rst_n_q;

  // Chains reset to the requesting level so the SoC stays in reset until the pads are seen idle.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], pad_reset_i};
      sync2_q <= {sync2_q[SYNC_STAGES-2:0], pad_reset2_i};
    end
  end

  assign req1  = sync1_q[SYNC_STAGES-1];
  assign req2  = ~sync2_q[SYNC_STAGES-1];
  assign req_s = req1 | req2;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (req_s == deb_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DcntMax) begin
      deb_d  = req_s;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    cause_d = cause_q;
    count_d = count_q;
    unique case (state_q)
      StHold: begin
        // A request seen while holding restarts the hold window without counting an event.
        if (deb_q) begin
          hcnt_d = '0;
        end else if (hcnt_q == HcntMax) begin
          state_d = StRun;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      StRun: begin
        if (deb_q) begin
          state_d = StHold;
          hcnt_d  = '0;
          cause_d = {req2, req1};
          if (count_q != 8'hff) begin
            count_d = count_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = StHold;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      state_q <= StHold;
      hcnt_q  <= '0;
      cause_q <= 2'b00;
      count_q <= 8'd0;
      rst_n_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      cause_q <= cause_d;
      count_q <= count_d;
      // Registered from the next state so rst_n_o tracks RUN on the same edge.
      rst_n_q <= (state_d == StRun);
    end
  end

  assign rst_n_o     = rst_n_q;
  assign rst_cause_o = cause_q;
  assign rst_count_o = count_q;

endmodule

// File: tb/tb_pulpissimo_rst_cond.sv
// Scoreboard bench for pulpissimo_rst_cond: expected rst_n_o edges (time, cause, count) are
// queued when stimulus is driven and matched when the DUT output toggles.
module tb_pulpissimo_rst_cond;

  localparam int unsigned S = 2;
  localparam int unsigned D = 8;
  localparam int unsigned H = 16;

  typedef struct packed {
    int unsigned edge_n;
    logic        level;
    logic [1:0]  cause;
    logic [7:0]  count;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pad1 = 1'b0;
  logic       pad2 = 1'b1;
  logic       rst_n;
  logic [1:0] cause;
  logic [7:0] count;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;
  logic [1:0]  exp_cause = 2'b00;
  logic        mon_en = 1'b0;
  logic        prev_rst_n;
  logic [9:0]  prev_cc;

  pulpissimo_rst_cond #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .ref_clk_i   (clk),
    .rst_i       (rst),
    .pad_reset_i (pad1),
    .pad_reset2_i(pad2),
    .rst_n_o     (rst_n),
    .rst_cause_o (cause),
    .rst_count_o (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Output monitor: every rst_n_o toggle must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_n !== prev_rst_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_edge", {31'd0, rst_n}, {31'd0, prev_rst_n});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("edge_time", cyc, e.edge_n);
          check("edge_level", {31'd0, rst_n}, {31'd0, e.level});
          check("edge_cause", {30'd0, cause}, {30'd0, e.cause});
          check("edge_count", {24'd0, count}, {24'd0, e.count});
        end
      end else if ({cause, count} !== prev_cc) begin
        check("cause_count_stable", {22'd0, cause, count}, {22'd0, prev_cc});
      end
      prev_rst_n = rst_n;
      prev_cc    = {cause, count};
    end
  end

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic press(input logic p1, input logic p2, input int unsigned len);
    int unsigned c;
    @(negedge clk);
    if (p1) pad1 = 1'b1;
    if (p2) pad2 = 1'b0;
    c = cyc;
    exp_cnt   = (exp_cnt == 8'hff) ? 8'hff : exp_cnt + 8'd1;
    exp_cause = {p2, p1};
    exp_q.push_back('{c + S + D + 1, 1'b0, exp_cause, exp_cnt});
    repeat (len) @(negedge clk);
    pad1 = 1'b0;
    pad2 = 1'b1;
    c = cyc;
    exp_q.push_back('{c + S + D + H, 1'b1, exp_cause, exp_cnt});
    wait_idle(len + S + D + H + 20);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c;
    // Power-on
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_rst_n", {31'd0, rst_n}, 0);
    check("reset_cause", {30'd0, cause}, 0);
    check("reset_count", {24'd0, count}, 0);
    prev_rst_n = rst_n;
    prev_cc    = {cause, count};
    mon_en     = 1'b1;
    rst = 1'b0;
    c = cyc;
    exp_q.push_back('{c + S + D + H, 1'b1, 2'b00, 8'd0});
    wait_idle(60);

    // Glitches shorter than D must be ignored
    pad1 = 1'b1;
    repeat (7) @(negedge clk);
    pad1 = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pad1 = 1'b1;
      @(negedge clk);
      pad1 = 1'b0;
      repeat (15) @(negedge clk);
    end
    check("glitch_rst_n", {31'd0, rst_n}, 1);
    check("glitch_count", {24'd0, count}, 0);

    press(1'b1, 1'b0, 30);
    press(1'b0, 1'b1, 30);
    press(1'b1, 1'b1, 30);

    // Re-press during HOLD once hcnt is running: hold restarts, no extra event
    @(negedge clk);
    pad1 = 1'b1;
    c = cyc;
    exp_cnt   = exp_cnt + 8'd1;
    exp_cause = 2'b01;
    exp_q.push_back('{c + S + D + 1, 1'b0, exp_cause, exp_cnt});
    repeat (30) @(negedge clk);
    pad1 = 1'b0;
    repeat (10) @(negedge clk);
    pad1 = 1'b1;
    repeat (12) @(negedge clk);
    pad1 = 1'b0;
    c = cyc;
    exp_q.push_back('{c + S + D + H, 1'b1, exp_cause, exp_cnt});
    wait_idle(80);
    check("repress_count", {24'd0, count}, 4);

    // Saturation
    for (int i = 0; i < 260; i++) press(1'b1, 1'b0, 12);
    check("sat_count", {24'd0, count}, 255);
    check("sat_rst_n", {31'd0, rst_n}, 1);

    // Mid-operation rst_i pulse restarts the power-on sequence
    @(negedge clk);
    rst = 1'b1;
    c = cyc;
    exp_cnt   = 8'd0;
    exp_cause = 2'b00;
    exp_q.push_back('{c + 1, 1'b0, 2'b00, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    exp_q.push_back('{c + S + D + H, 1'b1, 2'b00, 8'd0});
    wait_idle(60);
    check("post_reset_count", {24'd0, count}, 0);
    check("post_reset_cause", {30'd0, cause}, 0);

    press(1'b0, 1'b1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
